// File: rtl/approx_mult_pkg.sv
// Shared widths and arithmetic helpers for the approximate multiplier.
// row_sum builds the low-row term; ref_product is the full behavioural product.
package approx_mult_pkg;
   localparam int W    = 8;
   localparam int ZW   = 2 * W;
   localparam int MAXW = 64;

   function automatic logic [MAXW-1:0] row_sum(input logic [MAXW-1:0] x,
                                                input logic [MAXW-1:0] y,
                                                input int w, input int l, input int t,
                                                input logic exact);
      logic [MAXW-1:0] acc;
      logic [MAXW-1:0] row;
      logic [MAXW-1:0] keep;
      logic [MAXW-1:0] zmask;
      acc   = '0;
      keep  = (t >= MAXW) ? '0 : ({MAXW{1'b1}} << t);
      zmask = (2 * w >= MAXW) ? {MAXW{1'b1}} : ~({MAXW{1'b1}} << (2 * w));
      for (int i = 0; i < MAXW; i++) begin
         if (i < l && x[i]) begin
            row = y << i;
            acc = acc + (exact ? row : (row & keep));
         end
      end
      return acc & zmask;
   endfunction

   function automatic logic [MAXW-1:0] ref_product(input logic [MAXW-1:0] x,
                                                    input logic [MAXW-1:0] y,
                                                    input logic exact,
                                                    input int w, input int l, input int t);
      logic [MAXW-1:0] hi;
      logic [MAXW-1:0] zmask;
      zmask = (2 * w >= MAXW) ? {MAXW{1'b1}} : ~({MAXW{1'b1}} << (2 * w));
      hi    = (y * (x >> l)) << l;
      return (hi + row_sum(x, y, w, l, t, exact)) & zmask;
   endfunction
endpackage

// File: rtl/approx_mult_pipe_if.sv
// Operand/result stream bundle; slave is the multiplier side, master the source/sink side.
interface approx_mult_pipe_if #(
   parameter int W     = 8,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_x;
   logic [W-1:0]     in_y;
   logic             in_exact;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   out_z;
   logic [TAG_W-1:0] out_tag;
   logic             out_exact;

   modport master (
      output in_valid, in_x, in_y, in_exact, in_tag, out_ready,
      input  in_ready, out_valid, out_z, out_tag, out_exact
   );

   modport slave (
      input  in_valid, in_x, in_y, in_exact, in_tag, out_ready,
      output in_ready, out_valid, out_z, out_tag, out_exact
   );
endinterface

// File: rtl/approx_pp_rows.sv
// Combinational split of the product: exact upper rows (hi) and the L low rows (lo),
// the latter truncated below column T unless exact_i is set.
module approx_pp_rows
   import approx_mult_pkg::*;
#(
   parameter int W = 8,
   parameter int L = 2,
   parameter int T = 6
) (
   input  logic [W-1:0]   x_i,
   input  logic [W-1:0]   y_i,
   input  logic           exact_i,
   output logic [2*W-1:0] hi_o,
   output logic [2*W-1:0] lo_o
);
   localparam int PW = 2 * W;

   logic [W-1:0] x_hi;

   assign x_hi = x_i >> L;
   assign hi_o = (PW'(y_i) * PW'(x_hi)) << L;
   assign lo_o = PW'(row_sum(MAXW'(x_i), MAXW'(y_i), W, L, T, exact_i));
endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage approximate multiplier with valid/ready stream, tag pass-through and a
// saturating count of delivered approximate results.
module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int W     = 8,
   parameter int L     = 2,
   parameter int T     = 6,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   approx_mult_pipe_if.slave    bus,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     approx_cnt
);
   localparam int PW = 2 * W;

   logic             adv;
   logic [PW-1:0]    hi;
   logic [PW-1:0]    lo;

   logic             s1_valid_q;
   logic [PW-1:0]    s1_hi_q;
   logic [PW-1:0]    s1_lo_q;
   logic [TAG_W-1:0] s1_tag_q;
   logic             s1_exact_q;

   logic             out_valid_q;
   logic [PW-1:0]    out_z_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             out_exact_q;

   logic [CNT_W-1:0] approx_cnt_q;
   logic [CNT_W-1:0] approx_cnt_d;

   approx_pp_rows #(.W(W), .L(L), .T(T)) u_rows (
      .x_i     (bus.in_x),
      .y_i     (bus.in_y),
      .exact_i (bus.in_exact),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   // Whole pipe moves together; a held output stalls stage 1 and the input.
   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_hi_q     <= '0;
         s1_lo_q     <= '0;
         s1_tag_q    <= '0;
         s1_exact_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_z_q     <= '0;
         out_tag_q   <= '0;
         out_exact_q <= 1'b0;
      end else if (adv) begin
         s1_valid_q  <= bus.in_valid;
         s1_hi_q     <= hi;
         s1_lo_q     <= lo;
         s1_tag_q    <= bus.in_tag;
         s1_exact_q  <= bus.in_exact;
         out_valid_q <= s1_valid_q;
         out_z_q     <= s1_hi_q + s1_lo_q;
         out_tag_q   <= s1_tag_q;
         out_exact_q <= s1_exact_q;
      end
   end

   always_comb begin
      approx_cnt_d = approx_cnt_q;
      if (cnt_clr) begin
         approx_cnt_d = '0;
      end else if (out_valid_q && bus.out_ready && !out_exact_q && approx_cnt_q != {CNT_W{1'b1}}) begin
         approx_cnt_d = approx_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         approx_cnt_q <= '0;
      end else begin
         approx_cnt_q <= approx_cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_z     = out_z_q;
   assign bus.out_tag   = out_tag_q;
   assign bus.out_exact = out_exact_q;
   assign approx_cnt    = approx_cnt_q;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe: expected results queued at input handshake,
// compared in order at output handshake.
module tb_approx_mult_pipe;
   localparam int W     = 8;
   localparam int L     = 2;
   localparam int T     = 6;
   localparam int TAG_W = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             cnt_clr;
   logic [CNT_W-1:0] approx_cnt;

   approx_mult_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

   approx_mult_pipe #(.W(W), .L(L), .T(T), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cnt_clr    (cnt_clr),
      .approx_cnt (approx_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0]   z;
      logic [TAG_W-1:0] tag;
      logic             exact;
      int               acc;
   } exp_t;

   exp_t             sb[$];
   int               total = 0;
   int               bad   = 0;
   int               cyc_n = 0;
   bit               lat_chk;
   logic [CNT_W-1:0] exp_cnt;
   logic [2*W-1:0]   last_z;
   bit               prev_bp;
   logic [2*W-1:0]   prev_z;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Exact product minus the bits the truncated low rows drop.
   function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic e);
      logic [2*W-1:0] p;
      logic [2*W-1:0] low;
      p   = (2*W)'(x) * (2*W)'(y);
      low = ((2*W)'(1) << T) - (2*W)'(1);
      if (!e) begin
         for (int i = 0; i < L; i++) begin
            if (x[i]) p = p - ((((2*W)'(y)) << i) & low);
         end
      end
      return p;
   endfunction

   task automatic cyc(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic e, input logic [TAG_W-1:0] tg, input logic ordy,
                      input logic clr, output logic took);
      exp_t it;
      logic fin;
      logic fout;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_x      = x;
      bus.in_y      = y;
      bus.in_exact  = e;
      bus.in_tag    = tg;
      bus.out_ready = ordy;
      cnt_clr       = clr;
      #1;
      chk("cnt", approx_cnt, exp_cnt);
      if (prev_bp) begin
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_z", bus.out_z, prev_z);
      end
      if (bus.out_valid && !ordy) chk("rdy_bp", bus.in_ready, 0);
      if (!bus.out_valid) chk("rdy_idle", bus.in_ready, 1);
      fin  = v && bus.in_ready;
      fout = bus.out_valid && ordy;
      if (clr) exp_cnt = '0;
      if (fout) begin
         if (sb.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            it = sb.pop_front();
            chk("z", bus.out_z, it.z);
            chk("tag", bus.out_tag, it.tag);
            chk("exact", bus.out_exact, it.exact);
            if (lat_chk) chk("latency", cyc_n, it.acc + 2);
            last_z = bus.out_z;
            if (!clr && !it.exact && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
         end
      end
      if (fin) sb.push_back('{model(x, y, e), tg, e, cyc_n});
      prev_bp = bus.out_valid && !ordy;
      prev_z  = bus.out_z;
      took    = fin;
      cyc_n++;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic e,
                       input logic [TAG_W-1:0] tg);
      logic took;
      int   n;
      n    = 0;
      took = 1'b0;
      while (!took && n < 20) begin
         cyc(1'b1, x, y, e, tg, 1'b1, 1'b0, took);
         n++;
      end
      if (!took) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      logic took;
      int   n;
      n = 0;
      while (sb.size() > 0 && n < 50) begin
         cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, took);
         n++;
      end
      chk("drain", sb.size(), 0);
      cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, took);
   endtask

   initial begin
      logic           took;
      logic [W-1:0]   rx;
      logic [W-1:0]   ry;
      logic           re;
      logic [TAG_W-1:0] rt;
      int             acc_n;
      int             guard;

      rst           = 1'b1;
      cnt_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.in_exact  = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      exp_cnt       = '0;
      prev_bp       = 1'b0;
      last_z        = '0;
      prev_z        = '0;
      #12;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_z", bus.out_z, 0);
      chk("rst_tag", bus.out_tag, 0);
      chk("rst_exact", bus.out_exact, 0);
      chk("rst_cnt", approx_cnt, 0);
      chk("rst_ready", bus.in_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      lat_chk = 1'b1;
      send(8'hFF, 8'hFF, 1'b0, 4'h1);
      drain();
      chk("ff_approx", last_z, 16'hFD84);
      chk("cnt_after_approx", approx_cnt, 1);
      send(8'hFF, 8'hFF, 1'b1, 4'h2);
      drain();
      chk("ff_exact", last_z, 16'hFE01);
      chk("cnt_after_exact", approx_cnt, 1);
      send(8'h03, 8'h03, 1'b0, 4'h3);
      drain();
      chk("small_approx", last_z, 16'h0000);
      send(8'h10, 8'h10, 1'b0, 4'h4);
      drain();
      chk("hi_only", last_z, 16'h0100);
      chk("cnt_after_4", approx_cnt, 3);
      send(8'hA5, 8'h3C, 1'b0, 4'h5);
      send(8'h7F, 8'hC3, 1'b0, 4'h6);
      send(8'h5B, 8'hE7, 1'b1, 4'h7);
      drain();

      lat_chk = 1'b0;
      acc_n   = 0;
      guard   = 0;
      rx = 8'($urandom); ry = 8'($urandom); re = 1'($urandom); rt = 4'($urandom);
      while (acc_n < 20 && guard < 500) begin
         cyc(1'b1, rx, ry, re, rt, 1'($urandom_range(0, 1)), 1'b0, took);
         if (took) begin
            acc_n++;
            rx = 8'($urandom); ry = 8'($urandom); re = 1'($urandom); rt = 4'($urandom);
         end
         guard++;
      end
      chk("stream_accepted", acc_n, 20);
      drain();

      @(negedge clk);
      #2;
      force dut.approx_cnt_q = 16'hFFFE;
      #1;
      release dut.approx_cnt_q;
      exp_cnt = 16'hFFFE;
      send(8'h33, 8'h77, 1'b0, 4'h8);
      send(8'h35, 8'h77, 1'b0, 4'h9);
      send(8'h37, 8'h77, 1'b0, 4'hA);
      drain();
      chk("cnt_saturated", approx_cnt, 16'hFFFF);

      cyc(1'b1, 8'h55, 8'h33, 1'b0, 4'hB, 1'b0, 1'b0, took);
      chk("clr_accept", took, 1);
      cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, took);
      cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, took);
      chk("clr_held_valid", bus.out_valid, 1);
      cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, took);
      cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, took);
      chk("cnt_clr_prio", approx_cnt, 0);

      cyc(1'b1, 8'h9A, 8'hBC, 1'b0, 4'hC, 1'b1, 1'b0, took);
      cyc(1'b1, 8'h12, 8'h34, 1'b0, 4'hD, 1'b1, 1'b0, took);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      #1;
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_z", bus.out_z, 0);
      chk("midrst_tag", bus.out_tag, 0);
      chk("midrst_ready", bus.in_ready, 1);
      sb.delete();
      exp_cnt = '0;
      prev_bp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, took);
      lat_chk = 1'b1;
      send(8'hC8, 8'h0F, 1'b0, 4'hE);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
